pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Program-counter and fetch-control stage that drives the word address of the instruction memory.
- Holds the 32-bit byte-addressed PC and selects the next PC each cycle: sequential, branch, jump, or jump-register.
- Handles pipeline stall, halt, and address faults, and counts retired instructions.
- Sits directly upstream of the instruction memory; decode/execute logic feeds its control inputs.

Parameters:
- ADDR_WIDTH, 32: PC and target width in bits.
- IMEM_LENGTH, 256: number of 32-bit words in instruction memory; IMEM_AW = $clog2(IMEM_LENGTH).
- RESET_VECTOR, 32'h0000_0000: byte address loaded into the PC on reset; must be word aligned.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hold the PC this cycle.
- branch_taken  input  1  take the conditional branch.
- branch_offset  input  16  signed word offset (instruction imm16).
- jump  input  1  J/JAL absolute jump.
- jump_index  input  26  instruction index field.
- jump_reg  input  1  JR/JALR.
- reg_target  input  32  register byte address for jump_reg.
- halt  input  1  halt request from decode.
- pc  output  32  current PC (byte address).
- pc_plus4  output  32  pc + 4, for the JAL link value.
- imem_addr  output  IMEM_AW  equals pc[IMEM_AW+1:2]; goes to the instruction memory address.
- fetch_valid  output  1  pc is a legal fetch this cycle.
- halted  output  1  block is in HALT.
- fault  output  1  block is in FAULT.
- retired_count  output  32  number of instructions completed.

Behaviour:
- **State machine.** States are BOOT, RUN, HALT, FAULT.
- **Reset.** Reset is asynchronous and takes priority over everything. On assert:
  - state = BOOT, pc = RESET_VECTOR, retired_count = 0.
  - fetch_valid = 0, halted = 0, fault = 0.
  - Reset asserted mid-operation aborts immediately with the same values.
- **BOOT.** Lasts exactly one clk edge after reset deasserts. PC is unchanged, then state goes to RUN. fetch_valid = 0 during BOOT.
- **RUN.** fetch_valid = 1.
  - If stall = 1: pc holds, retired_count holds, and all control inputs are ignored, including halt.
  - Otherwise the next PC is chosen by priority: jump_reg > jump > branch_taken > sequential. Only one target is taken when several controls are asserted simultaneously.
- **Target arithmetic.** All arithmetic is modulo 2^32 and silently wraps.
  - Sequential: pc + 4.
  - Branch: pc_plus4 + (sign_extend(branch_offset) << 2).
  - Jump: {pc_plus4[31:28], jump_index, 2'b00}.
  - Jump-register: reg_target, unmodified.
- **Fault check.** Applied to the selected next PC.
  - A fault occurs if next[1:0] != 0, or if next >= 4*IMEM_LENGTH.
  - On fault: pc is not updated, state goes to FAULT, and the faulting instruction is not retired.
- **Retirement.** retired_count increments by 1 on every RUN edge with stall = 0 and no fault, including the edge on which halt is accepted. It wraps from 0xFFFF_FFFF to 0.
- **Halt.** halt = 1 with stall = 0 in RUN:
  - State goes to HALT and pc holds the halting instruction's address.
  - halt takes priority over jump, branch, and fault evaluation.
- **HALT.** pc and retired_count are frozen; halted = 1, fetch_valid = 0. Only reset exits this state.
- **FAULT.** pc is frozen at the last good address; fault = 1, fetch_valid = 0. Only reset exits this state.
- **Combinational outputs.** pc_plus4 and imem_addr are combinational from pc. The instruction is available combinationally from the memory in the same cycle.
- **Register timing.** halted and fault are registered and assert on the same edge as the state change.

Test Plan:
- Reset, then 4 unstalled cycles -> pc sequence 0x0 (BOOT), 0x0, 0x4, 0x8, 0xC; retired_count = 3 at pc = 0xC; imem_addr = 3.
- At pc = 0x10, branch_taken = 1 with branch_offset = 0xFFFE -> next pc = 0x0C. Then jump_index = 0x000_0020 -> pc = 0x80.
- At pc = 0x20, jump_reg = 1, jump = 1, branch_taken = 1 all together with reg_target = 0x40 -> pc = 0x40 (jump_reg wins).
- At pc = 0x08, stall held 3 cycles -> pc stays 0x08 and retired_count unchanged. A halt asserted during the stall is ignored.
- At pc = 0x8, jump_reg with reg_target = 0x402 -> fault = 1, pc stays 0x8, fetch_valid = 0.
- Separately, reg_target = 0x400 (IMEM_LENGTH = 256) -> fault.
- At pc = 0x14, halt = 1 -> halted = 1, pc = 0x14 frozen, retired_count incremented once. Reset asserted asynchronously mid-cycle -> pc = 0x0, halted = 0 immediately.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Program-counter and fetch-control stage. Holds the byte-addressed PC, picks
// the next PC every cycle (sequential, branch, jump, jump-register), and
// drives the word address of the instruction memory directly from the PC.
// Stops on a halt request or on an illegal next address, and counts retired
// instructions.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   stall          hold PC and retired count; all other controls ignored
//   branch_taken   take the conditional branch (signed word offset)
//   branch_offset  16-bit signed word offset (imm16)
//   jump           J/JAL absolute jump within the current 256 MB region
//   jump_index     26-bit instruction index field
//   jump_reg       JR/JALR, jump to reg_target
//   reg_target     register byte address for jump_reg
//   halt           halt request from decode
//   pc             current PC (byte address)
//   pc_plus4       pc + 4, used as the JAL link value
//   imem_addr      instruction memory word address, pc[IMEM_AW+1:2]
//   fetch_valid    pc is a legal fetch this cycle (RUN only)
//   halted         block is in HALT
//   fault          block is in FAULT
//   retired_count  number of instructions completed, wraps at 2^32
//
// State table:
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_BOOT  | first edge after reset; PC held at reset vector, no fetch
//   S_RUN   | fetching; PC advances each unstalled cycle
//   S_HALT  | halt accepted; PC and retired count frozen until reset
//   S_FAULT | illegal next PC seen; PC frozen at last good address
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter int                  ADDR_WIDTH   = 32,
    parameter int                  IMEM_LENGTH  = 256,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    localparam int                 IMEM_AW      = $clog2(IMEM_LENGTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [15:0]           branch_offset,
    input  logic                  jump,
    input  logic [25:0]           jump_index,
    input  logic                  jump_reg,
    input  logic [ADDR_WIDTH-1:0] reg_target,
    input  logic                  halt,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_plus4,
    output logic [IMEM_AW-1:0]    imem_addr,
    output logic                  fetch_valid,
    output logic                  halted,
    output logic                  fault,
    output logic [31:0]           retired_count
);

    // Byte size of the instruction memory; next PCs at or above this fault.
    localparam logic [ADDR_WIDTH-1:0] IMEM_BYTES = ADDR_WIDTH'(4 * IMEM_LENGTH);
    localparam int                    EXT_BITS   = ADDR_WIDTH - 18;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [31:0]             count_q, count_d;
    logic                    halted_q, halted_d;
    logic                    fault_q, fault_d;

    logic [ADDR_WIDTH-1:0]   seq_target;
    logic [ADDR_WIDTH-1:0]   branch_target;
    logic [ADDR_WIDTH-1:0]   jump_target;
    logic [ADDR_WIDTH-1:0]   next_target;
    logic                    target_bad;

    // ------------------------------------------------------------------
    // Target arithmetic. All sums wrap modulo 2^ADDR_WIDTH.
    // ------------------------------------------------------------------
    assign seq_target    = pc_q + ADDR_WIDTH'(4);
    assign branch_target = seq_target
                         + {{EXT_BITS{branch_offset[15]}}, branch_offset, 2'b00};
    // Jump keeps the region bits of the delay-slot address, not of pc.
    assign jump_target   = {seq_target[ADDR_WIDTH-1:28], jump_index, 2'b00};

    always_comb begin
        next_target = seq_target;
        if (jump_reg) begin
            next_target = reg_target;
        end else if (jump) begin
            next_target = jump_target;
        end else if (branch_taken) begin
            next_target = branch_target;
        end
    end

    assign target_bad = (next_target[1:0] != 2'b00) || (next_target >= IMEM_BYTES);

    // ------------------------------------------------------------------
    // State register and architectural registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_BOOT;
            pc_q     <= RESET_VECTOR;
            count_q  <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Halt is checked before the target fault so that a
    // halting instruction retires even if its would-be successor is illegal.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        count_d  = count_q;
        halted_d = halted_q;
        fault_d  = fault_q;

        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (!stall) begin
                    if (halt) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                        count_d  = count_q + 32'd1;
                    end else if (target_bad) begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                    end else begin
                        pc_d    = next_target;
                        count_d = count_q + 32'd1;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs.
    // ------------------------------------------------------------------
    assign pc            = pc_q;
    assign pc_plus4      = seq_target;
    assign imem_addr     = pc_q[IMEM_AW+1:2];
    assign fetch_valid   = (state_q == S_RUN);
    assign halted        = halted_q;
    assign fault         = fault_q;
    assign retired_count = count_q;

endmodule
